// File: rtl/serial_reg_decoder_pkg.sv
// Shared framing constants and receiver state encoding for the serial register decoder.
package serial_reg_decoder_pkg;

    localparam int unsigned FRAME_BITS   = 10;
    localparam logic        START_BIT    = 1'b0;
    localparam logic        STOP_BIT     = 1'b1;
    localparam int unsigned PAYLOAD_BITS = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_frame_rx.sv
// Bit-level framer: start bit, 8 payload bits LSB first, stop bit.
// valid_o/err_o are combinational and asserted only while the stop bit is on the line.
module serial_frame_rx
    import serial_reg_decoder_pkg::*;
(
    input  logic                    sck_i,
    input  logic                    rst_n_i,
    input  logic                    sdi_i,
    output logic [PAYLOAD_BITS-1:0] payload_o,
    output logic                    valid_o,
    output logic                    err_o
);

    localparam int unsigned CNT_W = $clog2(PAYLOAD_BITS);

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (sdi_i == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_d = {sdi_i, shift_q[PAYLOAD_BITS-1:1]};
                if (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                state_d = (sdi_i == STOP_BIT) ? IDLE : BREAK;
            end
            BREAK: begin
                if (sdi_i == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sck_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign payload_o = shift_q;
    assign valid_o   = (state_q == STOP) && (sdi_i == STOP_BIT);
    assign err_o     = (state_q == STOP) && (sdi_i != STOP_BIT);

endmodule

// File: rtl/serial_reg_decoder.sv
// Assembles serially received nibbles into registers; payload = {idx[2:0], last, data[3:0]}.
// Flags sequence/address violations and framing errors, with a saturating error count.
module serial_reg_decoder
    import serial_reg_decoder_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_WIDTH = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                          sck,
    input  logic                          rst_n,
    input  logic                          sdi,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs,
    output logic                          wr_stb,
    output logic [2:0]                    wr_addr,
    output logic                          frame_err,
    output logic                          seq_err,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int unsigned NIBS     = REG_WIDTH / 4;
    localparam logic [1:0]  NIB_LAST = 2'(NIBS - 1);

    logic [PAYLOAD_BITS-1:0] payload;
    logic                    rx_valid;
    logic                    rx_err;

    serial_frame_rx u_rx (
        .sck_i     (sck),
        .rst_n_i   (rst_n),
        .sdi_i     (sdi),
        .payload_o (payload),
        .valid_o   (rx_valid),
        .err_o     (rx_err)
    );

    logic [NUM_REGS*REG_WIDTH-1:0] regs_q, regs_d;
    logic [REG_WIDTH-5:0]          hold_q, hold_d;
    logic [1:0]                    nib_cnt_q, nib_cnt_d;
    logic                          wr_stb_q, wr_stb_d;
    logic [2:0]                    wr_addr_q, wr_addr_d;
    logic                          frame_err_q, frame_err_d;
    logic                          seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0]          err_count_q, err_count_d;

    logic [3:0]           data;
    logic                 last;
    logic [2:0]           idx;
    logic                 idx_ok;
    logic [REG_WIDTH-1:0] shifted;

    assign data    = payload[3:0];
    assign last    = payload[4];
    assign idx     = payload[7:5];
    assign idx_ok  = {1'b0, idx} < 4'(NUM_REGS);
    // New nibble enters at the top; the oldest nibble ends up in the low bits.
    assign shifted = {data, hold_q};

    always_comb begin
        regs_d      = regs_q;
        hold_d      = hold_q;
        nib_cnt_d   = nib_cnt_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        seq_err_d   = 1'b0;
        err_count_d = err_count_q;
        if (rx_err) begin
            frame_err_d = 1'b1;
            hold_d      = '0;
            nib_cnt_d   = '0;
        end else if (rx_valid) begin
            if (!last) begin
                if (nib_cnt_q == NIB_LAST) begin
                    seq_err_d = 1'b1;
                    hold_d    = '0;
                    nib_cnt_d = '0;
                end else begin
                    hold_d    = shifted[REG_WIDTH-1:4];
                    nib_cnt_d = nib_cnt_q + 2'd1;
                end
            end else begin
                hold_d    = '0;
                nib_cnt_d = '0;
                if ((nib_cnt_q == NIB_LAST) && idx_ok) begin
                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                        if (idx == 3'(k)) begin
                            regs_d[k*REG_WIDTH +: REG_WIDTH] = shifted;
                        end
                    end
                    wr_stb_d  = 1'b1;
                    wr_addr_d = idx;
                end else begin
                    seq_err_d = 1'b1;
                end
            end
        end
        if ((frame_err_d || seq_err_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '0;
            hold_q      <= '0;
            nib_cnt_q   <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            regs_q      <= regs_d;
            hold_q      <= hold_d;
            nib_cnt_q   <= nib_cnt_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign regs      = regs_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_serial_reg_decoder.sv
// Bench for serial_reg_decoder: three parameterisations driven by directed and random
// frames, every output compared each cycle against a nibble-list reference model.
module tb_serial_reg_decoder;

    logic sck = 1'b0;
    logic rst_n = 1'b0;
    logic sdi0 = 1'b1, sdi1 = 1'b1, sdi2 = 1'b1;

    logic [63:0]  regs0;
    logic [127:0] regs1;
    logic [31:0]  regs2;
    logic         ws0, ws1, ws2, fe0, fe1, fe2, se0, se1, se2;
    logic [2:0]   wa0, wa1, wa2;
    logic [7:0]   ec0, ec1;
    logic [3:0]   ec2;

    always #5 sck = ~sck;

    serial_reg_decoder u_def (
        .sck(sck), .rst_n(rst_n), .sdi(sdi0), .regs(regs0), .wr_stb(ws0),
        .wr_addr(wa0), .frame_err(fe0), .seq_err(se0), .err_count(ec0)
    );

    serial_reg_decoder #(.REG_WIDTH(16)) u_w16 (
        .sck(sck), .rst_n(rst_n), .sdi(sdi1), .regs(regs1), .wr_stb(ws1),
        .wr_addr(wa1), .frame_err(fe1), .seq_err(se1), .err_count(ec1)
    );

    serial_reg_decoder #(.NUM_REGS(4), .ERR_CNT_W(4)) u_n4 (
        .sck(sck), .rst_n(rst_n), .sdi(sdi2), .regs(regs2), .wr_stb(ws2),
        .wr_addr(wa2), .frame_err(fe2), .seq_err(se2), .err_count(ec2)
    );

    int cfg_w[3]    = '{8, 16, 8};
    int cfg_n[3]    = '{8, 8, 4};
    int cfg_emax[3] = '{255, 255, 15};

    int m_regs[3][8];
    int m_nib[3][4];
    int m_nn[3];
    int m_wa[3];
    int m_ec[3];
    bit e_ws, e_fe, e_se;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) m_regs[d][k] = 0;
            m_nn[d] = 0;
            m_wa[d] = 0;
            m_ec[d] = 0;
        end
        e_ws = 0; e_fe = 0; e_se = 0;
    endtask

    task automatic model_frame(input int d, input logic [7:0] p, input bit stopb);
        int nibs, data, idx, v;
        bit last;
        nibs = cfg_w[d] / 4;
        data = int'(p) % 16;
        last = p[4];
        idx  = int'(p) / 32;
        if (!stopb) begin
            e_fe = 1;
            m_nn[d] = 0;
        end else if (!last) begin
            if (m_nn[d] == nibs - 1) begin
                e_se = 1;
                m_nn[d] = 0;
            end else begin
                m_nib[d][m_nn[d]] = data;
                m_nn[d]++;
            end
        end else begin
            if (m_nn[d] == nibs - 1 && idx < cfg_n[d]) begin
                v = data * (1 << (4 * (nibs - 1)));
                for (int i = 0; i < m_nn[d]; i++) v += m_nib[d][i] * (1 << (4 * i));
                m_regs[d][idx] = v;
                m_wa[d] = idx;
                e_ws = 1;
            end else begin
                e_se = 1;
            end
            m_nn[d] = 0;
        end
        if ((e_fe || e_se) && m_ec[d] < cfg_emax[d]) m_ec[d]++;
    endtask

    task automatic observe(input int d);
        logic [127:0] er, r;
        logic ws, fe, se;
        logic [2:0] wa;
        logic [7:0] ec;
        er = '0;
        for (int k = 0; k < cfg_n[d]; k++) er |= 128'(m_regs[d][k]) << (k * cfg_w[d]);
        case (d)
            0: begin r = 128'(regs0); ws = ws0; fe = fe0; se = se0; wa = wa0; ec = ec0; end
            1: begin r = regs1;       ws = ws1; fe = fe1; se = se1; wa = wa1; ec = ec1; end
            default: begin r = 128'(regs2); ws = ws2; fe = fe2; se = se2; wa = wa2; ec = 8'(ec2); end
        endcase
        check($sformatf("d%0d regs", d), r, er);
        check($sformatf("d%0d wr_stb", d), 128'(ws), 128'(e_ws));
        check($sformatf("d%0d frame_err", d), 128'(fe), 128'(e_fe));
        check($sformatf("d%0d seq_err", d), 128'(se), 128'(e_se));
        check($sformatf("d%0d wr_addr", d), 128'(wa), 128'(m_wa[d]));
        check($sformatf("d%0d err_count", d), 128'(ec), 128'(m_ec[d]));
        e_ws = 0; e_fe = 0; e_se = 0;
    endtask

    task automatic drive_bit(input int d, input logic b);
        @(negedge sck);
        observe(d);
        case (d)
            0: sdi0 = b;
            1: sdi1 = b;
            default: sdi2 = b;
        endcase
    endtask

    task automatic send_frame(input int d, input logic [7:0] p, input bit stopb);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, p[i]);
        drive_bit(d, stopb);
        model_frame(d, p, stopb);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drive_bit(d, 1'b1);
    endtask

    task automatic rand_frames(input int d, input int n);
        logic [7:0] p;
        bit stopb;
        int nibs;
        nibs = cfg_w[d] / 4;
        for (int f = 0; f < n; f++) begin
            p = 8'($urandom);
            p[4] = ($urandom_range(0, nibs - 1) == 0);
            stopb = ($urandom_range(0, 15) != 0);
            send_frame(d, p, stopb);
            if (!stopb) idle(d, 1 + $urandom_range(0, 1));
            else idle(d, $urandom_range(0, 2));
        end
        idle(d, 2);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge sck);
        for (int d = 0; d < 3; d++) observe(d);
        rst_n = 1'b1;
        idle(0, 2);

        // Basic pair and back-to-back frames.
        send_frame(0, 8'h0A, 1'b1);
        send_frame(0, 8'h15, 1'b1);
        idle(0, 2);
        check("pair reg0", 128'(regs0[7:0]), 128'h5A);

        // Framing error, break, then recovery.
        send_frame(0, 8'h3C, 1'b0);
        idle(0, 1);
        send_frame(0, 8'h0A, 1'b1);
        send_frame(0, 8'h1F, 1'b1);
        idle(0, 2);
        check("ferr count", 128'(ec0), 128'd1);
        check("ferr reg0", 128'(regs0[7:0]), 128'hFA);

        // Last nibble with nothing held.
        send_frame(0, 8'h17, 1'b1);
        idle(0, 2);
        check("lone last reg0", 128'(regs0[7:0]), 128'hFA);
        check("lone last count", 128'(ec0), 128'd2);

        // 16-bit registers: full sequence, then an over-long sequence.
        idle(1, 1);
        send_frame(1, 8'h01, 1'b1);
        send_frame(1, 8'h02, 1'b1);
        send_frame(1, 8'h03, 1'b1);
        send_frame(1, 8'h74, 1'b1);
        idle(1, 2);
        check("w16 reg3", 128'(regs1[63:48]), 128'h4321);
        send_frame(1, 8'h01, 1'b1);
        send_frame(1, 8'h02, 1'b1);
        send_frame(1, 8'h03, 1'b1);
        send_frame(1, 8'h05, 1'b1);
        send_frame(1, 8'h74, 1'b1);
        idle(1, 2);
        check("w16 reg3 kept", 128'(regs1[63:48]), 128'h4321);

        // Out-of-range index, then counter saturation.
        idle(2, 1);
        send_frame(2, 8'h0A, 1'b1);
        send_frame(2, 8'h9B, 1'b1);
        idle(2, 2);
        check("n4 bad idx regs", 128'(regs2), 128'h0);
        for (int i = 0; i < 19; i++) begin
            send_frame(2, 8'($urandom), 1'b0);
            idle(2, 1);
        end
        idle(2, 1);
        check("n4 saturate", 128'(ec2), 128'hF);

        // Asynchronous reset mid-frame after payload bit 3.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst regs", 128'(regs0), 128'h0);
        check("rst err_count", 128'(ec0), 128'h0);
        check("rst wr_addr", 128'(wa0), 128'h0);
        check("rst pulses", 128'({ws0, fe0, se0}), 128'h0);
        sdi0 = 1'b1;
        @(negedge sck);
        rst_n = 1'b1;
        idle(0, 2);
        send_frame(0, 8'h0A, 1'b1);
        send_frame(0, 8'h15, 1'b1);
        idle(0, 2);
        check("post rst reg0", 128'(regs0[7:0]), 128'h5A);

        rand_frames(0, 150);
        rand_frames(1, 150);
        rand_frames(2, 150);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
